mac_sat_nbit_seq: RTL and testbench
===================================

Name: mac_sat_nbit_seq

Overview:
- Sequential signed multiply-accumulate neuron stage that sits directly upstream of the single-cycle ReLU block (sum_nbit_1cc).
- Consumes K (x, w) operand pairs over a valid/ready stream and adds a per-neuron bias.
- Saturates the accumulated sum to N-bit signed and presents it on s_output. s_output feeds the ReLU s_input port unmodified.

Parameters:
- N, 8, operand, bias and output width in bits (signed two's complement).
- K, 4, number of operand pairs per dot product; K >= 2.
- ACC_W (localparam), 2*N + $clog2(K) + 1, internal accumulator width; no overflow is possible inside it.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the clk rising edge.
- in_valid  input  1  x, w and bias are valid this cycle.
- in_ready  output  1  block accepts an operand beat this cycle.
- x  input  N  signed activation operand.
- w  input  N  signed weight operand.
- bias  input  N  signed bias; sampled only on the first beat of each dot product.
- out_valid  output  1  s_output holds a completed result.
- out_ready  input  1  downstream consumes the result this cycle.
- s_output  output  N  signed saturated sum; connects to the ReLU s_input.

Behaviour:
- Decided interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset (rst_n=0 at an edge):
  - state=ACC, count=0, acc=0.
  - out_valid=0, s_output=0.
  - in_ready is 1 from the first cycle after reset release.
  - Reset mid-dot-product discards the partial sum.
  - Reset in state OUT drops the pending result.
- States: ACC and OUT.
- ACC:
  - in_ready=1, out_valid=0.
  - A beat is in_valid & in_ready.
  - Each beat forms product = x*w, a 2N-bit signed result sign-extended to ACC_W.
  - count==0: acc_next = sext(bias) + product.
  - count>0: acc_next = acc + product.
  - Not last beat (count<K-1): acc<=acc_next, count<=count+1.
  - Last beat (count==K-1): s_output<=sat(acc_next), out_valid<=1, count<=0, acc<=0, state<=OUT.
  - in_valid=0 cycles: hold all state. Gaps between beats are legal.
- OUT:
  - in_ready=0, out_valid=1, s_output stable.
  - out_ready=1: out_valid<=0, state<=ACC.
  - out_ready=0: hold indefinitely (backpressure). x, w and bias are ignored.
- Latency:
  - out_valid rises on the cycle after the K-th beat.
  - Minimum spacing between result starts is K+1 cycles; there is no bypass of OUT into ACC.
- Saturation sat(v):
  - v > 2^(N-1)-1 gives 2^(N-1)-1 (0x7F for N=8).
  - v < -2^(N-1) gives -2^(N-1) (0x80).
  - Otherwise v[N-1:0].
  - Exact boundary values pass through unsaturated.
- in_ready is a pure function of state; it has no combinational path from in_valid or out_ready.
- out_valid and s_output are registered.

Test Plan (N=8, K=4):
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0, s_output=0x00, no beat counted. in_ready=1 on the first cycle after release.
- Basic dot product:
  - Stimulus: x=(3,-2,5,1), w=(4,7,2,-9), bias=10 on beat 0, back-to-back beats.
  - Required: out_valid=1 one cycle after beat 3, s_output=0x09; ReLU downstream gives 0x09.
- Saturation:
  - Positive: x=100, w=100 for all 4 beats, bias=0 -> s_output=0x7F.
  - Negative: x=-128, w=127 for all 4 beats, bias=-128 -> s_output=0x80.
  - Boundary: products summing to exactly 127 -> 0x7F with no clipping.
- Backpressure and gaps:
  - Stimulus: in_valid toggles 1,0,1,0,... across beats; out_ready held 0 for 5 cycles after out_valid.
  - Required: result unchanged, s_output stable, in_ready=0 throughout OUT.
  - After out_ready=1: out_valid=0 next cycle, and the next dot product starts with a fresh bias.
- Reset mid-operation: assert rst_n=0 after 2 beats, then run a full dot product with x=1, w=1, bias=0 -> s_output=0x04 (no leftover partial sum).

Source files
------------

// File: rtl/mac_sat_nbit_seq.sv
// mac_sat_nbit_seq: sequential signed multiply-accumulate neuron stage.
// Accumulates K (x*w) products plus a bias and presents the N-bit saturated sum.
//
// Ports:
//   clk       - clock, all state changes on the rising edge
//   rst_n     - synchronous active-low reset
//   in_valid  - x, w and bias are valid this cycle
//   in_ready  - block accepts an operand beat this cycle (state ACC)
//   x, w      - signed N-bit operand pair
//   bias      - signed N-bit bias, taken only on the first beat of a dot product
//   out_valid - s_output holds a completed result
//   out_ready - downstream consumes the result this cycle
//   s_output  - signed N-bit saturated sum, feeds the ReLU s_input

module mac_sat_nbit_seq #(
   parameter int N = 8,
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] x,
   input  logic [N-1:0] w,
   input  logic [N-1:0] bias,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s_output
);

   localparam int ACC_W = 2*N + $clog2(K) + 1;
   localparam int CW    = $clog2(K);
   localparam int PX_W  = ACC_W - 2*N;
   localparam int BX_W  = ACC_W - N;

   localparam logic [CW-1:0] LAST = CW'(K-1);

   // Saturation limits expressed at accumulator width.
   localparam logic signed [ACC_W-1:0] SMAX =
      {{(BX_W+1){1'b0}}, {(N-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN =
      {{(BX_W+1){1'b1}}, {(N-1){1'b0}}};

   typedef enum logic {
      ACC = 1'b0,
      OUT = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [CW-1:0]            count_q, count_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [N-1:0]             sout_q, sout_d;
   logic                     ov_q, ov_d;

   logic signed [N-1:0]      xs, ws;
   logic signed [2*N-1:0]    prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  bias_ext;
   logic signed [ACC_W-1:0]  acc_base;
   logic signed [ACC_W-1:0]  acc_next;
   logic [N-1:0]             acc_sat;
   logic                     beat;

   assign xs = x;
   assign ws = w;
   assign prod = xs * ws;

   assign prod_ext = {{PX_W{prod[2*N-1]}}, prod};
   assign bias_ext = {{BX_W{bias[N-1]}}, bias};

   // The first beat seeds the sum with the bias instead of the old acc.
   assign acc_base = (count_q == '0) ? bias_ext : acc_q;
   assign acc_next = acc_base + prod_ext;

   always_comb begin
      acc_sat = acc_next[N-1:0];
      if (acc_next > SMAX)
         acc_sat = SMAX[N-1:0];
      else if (acc_next < SMIN)
         acc_sat = SMIN[N-1:0];
   end

   // in_ready depends on state only.
   assign in_ready = (state_q == ACC);
   assign beat     = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      acc_d   = acc_q;
      sout_d  = sout_q;
      ov_d    = ov_q;
      unique case (state_q)
         ACC: begin
            ov_d = 1'b0;
            if (beat) begin
               if (count_q == LAST) begin
                  sout_d  = acc_sat;
                  ov_d    = 1'b1;
                  count_d = '0;
                  acc_d   = '0;
                  state_d = OUT;
               end else begin
                  acc_d   = acc_next;
                  count_d = count_q + 1'b1;
               end
            end
         end
         OUT: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = ACC;
            end
         end
         default: begin
            state_d = ACC;
            count_d = '0;
            acc_d   = '0;
            ov_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ACC;
         count_q <= '0;
         acc_q   <= '0;
         sout_q  <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         acc_q   <= acc_d;
         sout_q  <= sout_d;
         ov_q    <= ov_d;
      end
   end

   assign out_valid = ov_q;
   assign s_output  = sout_q;

endmodule

// File: tb/tb_mac_sat_nbit_seq.sv
// tb_mac_sat_nbit_seq: directed scoreboard bench for mac_sat_nbit_seq.
// Expected sums come from an integer reference model of the dot product.

module tb_mac_sat_nbit_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] x, w, bias;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] s_output;

   int vectors = 0;
   int miscompares = 0;

   int vx[4];
   int vw[4];
   logic [7:0] sb[$];

   mac_sat_nbit_seq #(.N(8), .K(4)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .x(x),
      .w(w),
      .bias(bias),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s_output(s_output)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model(input int b);
      int s;
      s = b;
      for (int i = 0; i < 4; i++) s += vx[i] * vw[i];
      if (s > 127) s = 127;
      else if (s < -128) s = -128;
      return s[7:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Feed one dot product; bias is randomised on non-first beats.
   task automatic run_dot(input string tag, input int b, input bit gaps);
      logic [7:0] exp;
      sb.push_back(model(b));
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         x = 8'(vx[i]);
         w = 8'(vw[i]);
         bias = (i == 0) ? 8'(b) : 8'($urandom);
         chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
         tick();
         in_valid = 1'b0;
         if (i < 3) chk({tag, "_early_valid"}, 32'(out_valid), 32'd0);
         if (gaps && i < 3) begin
            x = 8'($urandom);
            w = 8'($urandom);
            bias = 8'($urandom);
            tick();
         end
      end
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk({tag, "_s_output"}, 32'(s_output), 32'(exp));
      drain(tag, 0, exp);
   endtask

   // Hold backpressure for 'hold' cycles with garbage on the input side.
   task automatic drain(input string tag, input int hold,
                        input logic [7:0] exp);
      for (int c = 0; c < hold; c++) begin
         out_ready = 1'b0;
         in_valid = 1'b1;
         x = 8'($urandom);
         w = 8'($urandom);
         bias = 8'($urandom);
         tick();
         chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         chk({tag, "_hold_data"}, 32'(s_output), 32'(exp));
         chk({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_drained"}, 32'(out_valid), 32'd0);
      chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
   endtask

   task automatic set4(input int a0, a1, a2, a3, b0, b1, b2, b3);
      vx[0] = a0; vx[1] = a1; vx[2] = a2; vx[3] = a3;
      vw[0] = b0; vw[1] = b1; vw[2] = b2; vw[3] = b3;
   endtask

   initial begin
      logic [7:0] exp;
      rst_n = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b0;
      x = 8'd5;
      w = 8'd5;
      bias = 8'd5;

      // Reset held 3 cycles with in_valid high.
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_s_output", 32'(s_output), 32'd0);
      end
      in_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      chk("rel_out_valid", 32'(out_valid), 32'd0);

      // Basic: 12-14+10-9+10 = 9.
      set4(3, -2, 5, 1, 4, 7, 2, -9);
      run_dot("basic", 10, 1'b0);

      // Positive saturation.
      set4(100, 100, 100, 100, 100, 100, 100, 100);
      run_dot("pos_sat", 0, 1'b0);

      // Negative saturation.
      set4(-128, -128, -128, -128, 127, 127, 127, 127);
      run_dot("neg_sat", -128, 1'b0);

      // Exactly 127: 100+25+12-10.
      set4(10, 5, 3, 0, 10, 5, 4, 0);
      run_dot("bnd_127", -10, 1'b0);

      // Exactly 128 clips.
      run_dot("bnd_128", -9, 1'b0);

      // Exactly -128 passes, -129 clips.
      set4(0, 0, 0, 0, 0, 0, 0, 0);
      run_dot("bnd_m128", -128, 1'b0);
      set4(-1, 0, 0, 0, 1, 0, 0, 0);
      run_dot("bnd_m129", -128, 1'b0);

      // Gaps between beats, then 5 cycles of backpressure.
      set4(3, -2, 5, 1, 4, 7, 2, -9);
      sb.push_back(model(-20));
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         x = 8'(vx[i]);
         w = 8'(vw[i]);
         bias = (i == 0) ? 8'(-20) : 8'($urandom);
         tick();
         in_valid = 1'b0;
         if (i < 3) begin
            x = 8'($urandom);
            tick();
         end
      end
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      chk("bp_s_output", 32'(s_output), 32'(exp));
      drain("bp", 5, exp);

      // Next product must start from a fresh bias.
      set4(2, 2, 2, 2, 3, 3, 3, 3);
      run_dot("fresh", 7, 1'b1);

      // Reset after 2 beats discards the partial sum.
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1;
         x = 8'd7;
         w = 8'd7;
         bias = 8'd50;
         tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      set4(1, 1, 1, 1, 1, 1, 1, 1);
      run_dot("mid_rst", 0, 1'b0);

      // Reset while a result is pending drops it.
      set4(1, 1, 1, 1, 1, 1, 1, 1);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         x = 8'd1;
         w = 8'd1;
         bias = 8'd0;
         tick();
      end
      in_valid = 1'b0;
      chk("out_rst_pre", 32'(out_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("out_rst_valid", 32'(out_valid), 32'd0);
      chk("out_rst_data", 32'(s_output), 32'd0);
      chk("out_rst_ready", 32'(in_ready), 32'd1);

      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
